// File: rtl/maze_pkg.sv
// Shared definitions for the maze agent: action codes, FSM states, cell geometry.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package maze_pkg;

    localparam logic [1:0] ACT_UP    = 2'd0;
    localparam logic [1:0] ACT_DOWN  = 2'd1;
    localparam logic [1:0] ACT_LEFT  = 2'd2;
    localparam logic [1:0] ACT_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        MOVE   = 3'd2,
        END    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Row of a row-major cell index for a grid that is cols wide.
    function automatic int unsigned cell_row(input int unsigned idx, input int unsigned cols);
        return idx / cols;
    endfunction

    // Column of a row-major cell index for a grid that is cols wide.
    function automatic int unsigned cell_col(input int unsigned idx, input int unsigned cols);
        return idx % cols;
    endfunction

endpackage

// File: rtl/maze_lfsr16.sv
// Seeded 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the exploration noise source.
// Latency: new value every enabled cycle; output is the register itself.
// Backpressure: none; the enable simply freezes the sequence.
module maze_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic        fb_d;

    assign fb_d   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_o = lfsr_q;

    // Shift left, feeding the tap XOR into bit 0; seed must be non-zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= {lfsr_q[14:0], fb_d};
        end
    end

endmodule

// File: rtl/maze_agent_ctrl.sv
// Epsilon-greedy maze agent controller: picks actions, moves the agent, ends and restarts episodes.
// Latency: 2 cycles per step minimum (greedy_valid sampled in SELECT, action_valid the next cycle), +1 END cycle per episode end.
// Backpressure: waits in SELECT until greedy_valid; greedy_valid and start are ignored in all other states.
module maze_agent_ctrl
    import maze_pkg::*;
#(
    parameter int          ROWS         = 5,
    parameter int          COLS         = 5,
    parameter int          ST_W         = 6,
    parameter int          EPS_W        = 16,
    parameter int          EP_W         = 10,
    parameter int          MAX_STEPS    = 32,
    parameter int          MAX_EPISODES = 300,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 enb,
    input  logic                 start,
    input  logic [ST_W-1:0]      start_st,
    input  logic [ST_W-1:0]      goal_st,
    input  logic [ROWS*COLS-1:0] wall_map,
    input  logic [EPS_W-1:0]     epsilon,
    input  logic [1:0]           greedy_action,
    input  logic                 greedy_valid,
    output logic [ST_W-1:0]      current_st,
    output logic [1:0]           next_action_o,
    output logic                 action_valid,
    output logic [EP_W-1:0]      episode,
    output logic [ST_W:0]        step_cnt,
    output logic                 fail,
    output logic                 finish,
    output logic                 new_gen,
    output logic                 done_all
);

    localparam int NCELL = ROWS * COLS;

    state_t            state_q;
    logic [ST_W-1:0]   current_st_q;
    logic [1:0]        act_q;
    logic              act_vld_q;
    logic [EP_W-1:0]   episode_q;
    logic [ST_W:0]     step_cnt_q;
    logic              fail_q;
    logic              finish_q;
    logic              new_gen_q;
    logic              done_q;

    logic [15:0]       lfsr_q;
    logic [EPS_W-1:0]  rnd_d;
    logic              explore_d;
    logic [1:0]        sel_act_d;

    int unsigned       row_d;
    int unsigned       col_d;
    logic [ST_W-1:0]   tgt_d;
    logic              bnd_d;
    logic              wall_d;
    logic              goal_d;
    logic [ST_W:0]     steps_inc_d;
    logic              tmo_d;
    logic [EP_W-1:0]   ep_inc_d;
    logic              last_ep_d;

    // The LFSR runs freely whenever the block is out of reset.
    maze_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk),
        .rst_ni (enb),
        .en_i   (1'b1),
        .lfsr_o (lfsr_q)
    );

    assign rnd_d     = EPS_W'(lfsr_q);
    assign explore_d = (rnd_d < epsilon);
    assign sel_act_d = explore_d ? lfsr_q[1:0] : greedy_action;

    // Target cell and the checks that decide how the committed step resolves.
    always_comb begin
        row_d  = cell_row(32'(current_st_q), COLS);
        col_d  = cell_col(32'(current_st_q), COLS);
        tgt_d  = current_st_q;
        bnd_d  = 1'b0;
        unique case (act_q)
            ACT_UP: begin
                bnd_d = (row_d == 0);
                tgt_d = current_st_q - ST_W'(COLS);
            end
            ACT_DOWN: begin
                bnd_d = (row_d == ROWS - 1);
                tgt_d = current_st_q + ST_W'(COLS);
            end
            ACT_LEFT: begin
                bnd_d = (col_d == 0);
                tgt_d = current_st_q - ST_W'(1);
            end
            default: begin
                bnd_d = (col_d == COLS - 1);
                tgt_d = current_st_q + ST_W'(1);
            end
        endcase
        // A shifted one-hot probe keeps out-of-range targets from reading a wall.
        wall_d      = |(wall_map & (NCELL'(1) << tgt_d));
        goal_d      = (tgt_d == goal_st);
        steps_inc_d = step_cnt_q + (ST_W + 1)'(1);
        tmo_d       = (steps_inc_d == (ST_W + 1)'(MAX_STEPS));
        ep_inc_d    = (episode_q == '1) ? episode_q : episode_q + EP_W'(1);
        last_ep_d   = ((32'(episode_q) + 32'd1) == 32'(MAX_EPISODES));
    end

    // Episode FSM; fail_q/finish_q are set on entry to END so they act as the pending flags.
    always_ff @(posedge clk or negedge enb) begin
        if (!enb) begin
            state_q      <= IDLE;
            current_st_q <= '0;
            act_q        <= '0;
            act_vld_q    <= 1'b0;
            episode_q    <= '0;
            step_cnt_q   <= '0;
            fail_q       <= 1'b0;
            finish_q     <= 1'b0;
            new_gen_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            act_vld_q <= 1'b0;
            fail_q    <= 1'b0;
            finish_q  <= 1'b0;
            new_gen_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        current_st_q <= start_st;
                        step_cnt_q   <= '0;
                        state_q      <= SELECT;
                    end
                end
                SELECT: begin
                    if (greedy_valid) begin
                        act_q     <= sel_act_d;
                        act_vld_q <= 1'b1;
                        state_q   <= MOVE;
                    end
                end
                MOVE: begin
                    step_cnt_q <= steps_inc_d;
                    if (bnd_d || wall_d) begin
                        fail_q    <= 1'b1;
                        new_gen_q <= 1'b1;
                        state_q   <= END;
                    end else if (goal_d) begin
                        current_st_q <= tgt_d;
                        finish_q     <= 1'b1;
                        new_gen_q    <= 1'b1;
                        state_q      <= END;
                    end else if (tmo_d) begin
                        current_st_q <= tgt_d;
                        fail_q       <= 1'b1;
                        new_gen_q    <= 1'b1;
                        state_q      <= END;
                    end else begin
                        current_st_q <= tgt_d;
                        state_q      <= SELECT;
                    end
                end
                END: begin
                    episode_q    <= ep_inc_d;
                    step_cnt_q   <= '0;
                    current_st_q <= start_st;
                    done_q       <= last_ep_d;
                    state_q      <= last_ep_d ? DONE : SELECT;
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign current_st    = current_st_q;
    assign next_action_o = act_q;
    assign action_valid  = act_vld_q;
    assign episode       = episode_q;
    assign step_cnt      = step_cnt_q;
    assign fail          = fail_q;
    assign finish        = finish_q;
    assign new_gen       = new_gen_q;
    assign done_all      = done_q;

endmodule
